truth_table_sweeper: RTL and testbench

Parametrised hardware sweep engine for the combinational exercises. It drives every one of the 2^K input combinations onto a DUT and holds each one for a programmable settle time. Each cycle of checking compares the DUT outputs against a golden-model output under a mask, then reports the error count and the first failing vector. It sits between a DUT and its reference model in a bench or an on-board self-test, and replaces the hand-written per-exercise input loops. It always covers the final vector 2^K-1.

---
 rtl/truth_table_sweeper.sv | 153 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive input sweep engine with masked output compare
//
// Drives all 2^K input combinations onto a DUT and its golden model, holds each
// one for HOLD settle cycles, then compares the outputs for one CHECK cycle under
// CMP_MASK. It reports a saturating mismatch count and the first failing vector.
//
// Configuration macro: SWEEP_GRAY_EN
//   defined   - vectors are issued in Gray order (vector(i) = i ^ (i >> 1))
//   undefined - vectors are issued in binary order (vector(i) = i)
//
// Ports:
//   clk             in   system clock, rising edge
//   reset           in   asynchronous active-low reset
//   start           in   begin a sweep from IDLE or DONE (ignored while busy)
//   abort           in   stop a running sweep, results frozen, back to IDLE
//   dut_out         in   [OUTS] DUT outputs
//   ref_out         in   [OUTS] golden-model outputs
//   vec             out  [K] input combination driven to DUT and reference
//   busy            out  sweep in progress (SETTLE or CHECK)
//   done            out  sweep completed (level)
//   pass            out  done with zero mismatches
//   err_count       out  [ERRW] number of mismatching vectors, saturating
//   first_err_vec   out  [K] vec value of the first mismatch
//   first_err_valid out  first_err_vec holds a captured value
module truth_table_sweeper #(
  parameter int K    = 4,
  parameter int OUTS = 2,
  parameter int HOLD = 1,
  parameter int ERRW = K + 1,
  parameter logic [OUTS-1:0] CMP_MASK = {OUTS{1'b1}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [OUTS-1:0] dut_out,
  input  logic [OUTS-1:0] ref_out,
  output logic [K-1:0]    vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic [K-1:0]    first_err_vec,
  output logic            first_err_valid
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  // Index is one bit wider than the vector so the terminal compare never wraps.
  localparam logic [K:0] LAST_IDX = {1'b0, {K{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  state_t        state;
  logic [K:0]    idx;
  logic [CW-1:0] cnt;

  logic            mismatch;
  logic [K:0]      idx_inc;
  logic [ERRW-1:0] err_inc;

  function automatic logic [K-1:0] vector_of(input logic [K-1:0] i);
`ifdef SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  assign mismatch = |((dut_out ^ ref_out) & CMP_MASK);
  assign idx_inc  = idx + 1'b1;
  assign err_inc  = (&err_count) ? err_count : err_count + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      idx             <= '0;
      cnt             <= '0;
      vec             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= SETTLE;
            idx             <= '0;
            cnt             <= '0;
            vec             <= vector_of('0);
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
          end
        end

        SETTLE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == CW'(HOLD - 1)) begin
            state <= CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        CHECK: begin
          // Abort wins over the compare: results stay exactly as they were.
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (mismatch) begin
              err_count <= err_inc;
              if (!first_err_valid) begin
                first_err_vec   <= vec;
                first_err_valid <= 1'b1;
              end
            end
            if (idx == LAST_IDX) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              // Pass reflects the count after this final compare.
              pass  <= (err_count == '0) && !mismatch;
            end else begin
              state <= SETTLE;
              idx   <= idx_inc;
              cnt   <= '0;
              vec   <= vector_of(idx_inc[K-1:0]);
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic reset;
  logic start_a, start_b, start_c;
  logic abort_a;
  logic abort_off = 1'b0;

  always #5 clk = ~clk;

  // Instance A: K=4, HOLD=1, full mask, clean DUT
  logic [1:0] dut_a, ref_a;
  logic [3:0] vec_a, fev_a;
  logic [4:0] err_a;
  logic busy_a, done_a, pass_a, fevv_a;

  // Instance B: K=3, HOLD=2, DUT output 0 wrong at vec 5 and 7
  logic [1:0] dut_b, ref_b;
  logic [2:0] vec_b, fev_b;
  logic [3:0] err_b;
  logic busy_b, done_b, pass_b, fevv_b;

  // Instance C: K=4, HOLD=1, mask 2'b10, DUT output 0 always wrong
  logic [1:0] dut_c, ref_c;
  logic [3:0] vec_c, fev_c;
  logic [4:0] err_c;
  logic busy_c, done_c, pass_c, fevv_c;

  assign ref_a = {vec_a[0] ^ vec_a[3], &vec_a[2:1]};
  assign dut_a = ref_a;
  assign ref_b = {vec_b[1] | vec_b[2], ^vec_b};
  assign dut_b = ref_b ^ {1'b0, (vec_b == 3'd5) || (vec_b == 3'd7)};
  assign ref_c = {vec_c[2], vec_c[1] & vec_c[0]};
  assign dut_c = ref_c ^ 2'b01;

  truth_table_sweeper #(.K(4), .OUTS(2), .HOLD(1)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .dut_out(dut_a), .ref_out(ref_a), .vec(vec_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_err_vec(fev_a), .first_err_valid(fevv_a)
  );

  truth_table_sweeper #(.K(3), .OUTS(2), .HOLD(2)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_off),
    .dut_out(dut_b), .ref_out(ref_b), .vec(vec_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err_vec(fev_b), .first_err_valid(fevv_b)
  );

  truth_table_sweeper #(.K(4), .OUTS(2), .HOLD(1), .CMP_MASK(2'b10)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .abort(abort_off),
    .dut_out(dut_c), .ref_out(ref_c), .vec(vec_c), .busy(busy_c),
    .done(done_c), .pass(pass_c), .err_count(err_c),
    .first_err_vec(fev_c), .first_err_valid(fevv_c)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] sbq[$];

  function automatic logic [3:0] vmod(input int i);
    logic [3:0] b;
    b = 4'(i);
`ifdef SWEEP_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a();
    for (int i = 0; i < 16; i++) sbq.push_back(vmod(i));
  endtask

  // Scoreboard consumer: every new vector A presents must match the queue head.
  logic       a_prev_busy = 1'b0;
  logic [3:0] a_prev_vec  = '0;
  always @(negedge clk) begin
    if (busy_a && (!a_prev_busy || vec_a != a_prev_vec)) begin
`ifdef SWEEP_GRAY_EN
      if (a_prev_busy) chk("a_hamming", $countones(vec_a ^ a_prev_vec), 1);
`endif
      chk("a_sb_nonempty", 32'(sbq.size() > 0), 1);
      if (sbq.size() > 0) chk("a_vec", vec_a, sbq.pop_front());
    end
    a_prev_busy = busy_a;
    a_prev_vec  = vec_a;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, da, db, dc;
    logic [2:0] exp_first_b;
    logic       found;

    reset = 1'b0;
    start_a = 0; start_b = 0; start_c = 0; abort_a = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vec", vec_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_fev", fev_a, 0);
    chk("rst_fevv", fevv_a, 0);
    @(negedge clk) reset = 1'b1;

    // Full sweeps on all three instances from the same start edge.
    @(negedge clk);
    start_a = 1; start_b = 1; start_c = 1;
    push_a();
    @(posedge clk);
    #1;
    start_a = 0; start_b = 0; start_c = 0;
    chk("start_latency_busy", busy_a, 1);
    chk("start_latency_vec", vec_a, vmod(0));
    n = 0; da = 0; db = 0; dc = 0;
    while (!(done_a && done_b && done_c) && n < 400) begin
      @(posedge clk);
      n++;
      #1;
      if (done_a && da == 0) da = n;
      if (done_b && db == 0) db = n;
      if (done_c && dc == 0) dc = n;
    end
    chk("a_done_cycle", da, 32);
    chk("b_done_cycle", db, 24);
    chk("c_done_cycle", dc, 32);
    chk("a_pass", pass_a, 1);
    chk("a_err", err_a, 0);
    chk("a_fevv", fevv_a, 0);
    chk("a_busy_done", busy_a, 0);
    chk("a_vec_hold", vec_a, vmod(15));
    chk("a_sb_drained", sbq.size(), 0);

    exp_first_b = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] v;
      v = vmod(i);
      if (!found && (v[2:0] == 3'd5 || v[2:0] == 3'd7)) begin
        exp_first_b = v[2:0];
        found = 1'b1;
      end
    end
    chk("b_err", err_b, 2);
    chk("b_fev", fev_b, exp_first_b);
    chk("b_fevv", fevv_b, 1);
    chk("b_pass", pass_b, 0);
    chk("c_err", err_c, 0);
    chk("c_pass", pass_c, 1);

    // Abort A during CHECK of index 6 (entered on edge 13 after start).
    @(negedge clk);
    start_a = 1;
    push_a();
    @(posedge clk);
    #1 start_a = 0;
    repeat (13) @(posedge clk);
    #1 abort_a = 1;
    @(posedge clk);
    #1 abort_a = 0;
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_vec", vec_a, vmod(6));
    chk("abort_err", err_a, 0);
    sbq.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("abort_idle_busy", busy_a, 0);
    chk("abort_idle_vec", vec_a, vmod(6));

    // Restart after abort, with a stray start pulse mid-sweep.
    @(negedge clk);
    start_a = 1;
    push_a();
    @(posedge clk);
    #1 start_a = 0;
    chk("restart_vec", vec_a, vmod(0));
    chk("restart_busy", busy_a, 1);
    n = 0; da = 0;
    while (!done_a && n < 400) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 7) start_a = 1;
      if (n == 8) start_a = 0;
      if (done_a && da == 0) da = n;
    end
    chk("restart_done_cycle", da, 32);
    chk("restart_pass", pass_a, 1);
    chk("restart_sb_drained", sbq.size(), 0);

    // B restart clears its counters; then reset lands mid-sweep.
    @(negedge clk);
    start_a = 1; start_b = 1;
    push_a();
    @(posedge clk);
    #1;
    start_a = 0; start_b = 0;
    chk("b_clr_err", err_b, 0);
    chk("b_clr_fevv", fevv_b, 0);
    chk("b_clr_busy", busy_b, 1);
    chk("b_clr_vec", vec_b, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("b_pre_reset_err", err_b, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_a_vec", vec_a, 0);
    chk("arst_a_busy", busy_a, 0);
    chk("arst_a_done", done_a, 0);
    chk("arst_b_busy", busy_b, 0);
    chk("arst_b_vec", vec_b, 0);
    chk("arst_b_err", err_b, 0);
    chk("arst_b_fev", fev_b, 0);
    chk("arst_b_fevv", fevv_b, 0);
    chk("arst_b_pass", pass_b, 0);
    sbq.delete();
    @(negedge clk) reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_busy", busy_a, 0);
    chk("post_rst_vec", vec_a, 0);
    chk("post_rst_done", done_a, 0);
    chk("post_rst_b_busy", busy_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
